// File: rtl/binary_popcount_accumulator.sv
// Popcount accumulator for binary (XNOR) dot products: sums NUM_BEATS beats of IN_SIZE product bits.
// Optional macro BINARY_POPCOUNT_THRESHOLD_EN adds a registered threshold bit (data_out_bin).
module binary_popcount_accumulator #(
    parameter int IN_SIZE   = 4,
    parameter int NUM_BEATS = 4,
    parameter int OUT_WIDTH = $clog2(IN_SIZE*NUM_BEATS+1),
    parameter int THRESHOLD = IN_SIZE*NUM_BEATS/2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in [IN_SIZE],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
    output logic                 data_out_bin,
`endif
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS-1);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    if (IN_SIZE < 1 || NUM_BEATS < 1 || THRESHOLD < 0 ||
        (64'(1) << OUT_WIDTH) <= 64'(IN_SIZE*NUM_BEATS)) begin : g_param_check
        $error("binary_popcount_accumulator: illegal parameter set");
    end

    function automatic logic [OUT_WIDTH-1:0] popcount(input logic [IN_SIZE-1:0] bits);
        logic [OUT_WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            sum = sum + OUT_WIDTH'(bits[i]);
        end
        return sum;
    endfunction

    logic [0:0]           state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [IN_SIZE-1:0]   beat_bits;
    logic [OUT_WIDTH-1:0] beat_sum;

    always_comb begin
        beat_bits = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            beat_bits[i] = data_in[i];
        end
    end

    // Running total including the current beat; cannot exceed IN_SIZE*NUM_BEATS.
    assign beat_sum = acc + popcount(beat_bits);

    // Ready depends only on FSM state (and reset), never on data_out_ready.
    assign data_in_ready  = (state == ST_ACC) && !rst;
    assign data_out_valid = (state == ST_OUT);

`ifdef BINARY_POPCOUNT_THRESHOLD_EN
    logic thr_hit;
    assign thr_hit = (int'(beat_sum) >= THRESHOLD);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ACC;
            beat_cnt <= '0;
            acc      <= '0;
            data_out <= '0;
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
            data_out_bin <= 1'b0;
`endif
        end else begin
            case (state)
                ST_ACC: begin
                    if (data_in_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            data_out <= beat_sum;
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
                            data_out_bin <= thr_hit;
`endif
                            acc      <= '0;
                            beat_cnt <= '0;
                            state    <= ST_OUT;
                        end else begin
                            acc      <= beat_sum;
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (data_out_ready) begin
                        state <= ST_ACC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_popcount_accumulator.sv
// Directed bench for binary_popcount_accumulator: table vectors plus stall, gap, reset and NUM_BEATS=1 sequences.
module tb_binary_popcount_accumulator;

    localparam int IN_SIZE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       din [IN_SIZE] = '{default: 1'b0};
    logic       vin  = 1'b0;
    logic       rdy;
    logic [4:0] dout;
    logic       vout;
    logic       ordy = 1'b0;

    logic       din1 [IN_SIZE] = '{default: 1'b0};
    logic       vin1  = 1'b0;
    logic       rdy1;
    logic [2:0] dout1;
    logic       vout1;
    logic       ordy1 = 1'b0;

`ifdef BINARY_POPCOUNT_THRESHOLD_EN
    logic       bin;
    logic       bin1;
`endif

    always #5 clk = ~clk;

    binary_popcount_accumulator #(.IN_SIZE(4), .NUM_BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(vin), .data_in_ready(rdy),
        .data_out(dout),
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
        .data_out_bin(bin),
`endif
        .data_out_valid(vout), .data_out_ready(ordy)
    );

    binary_popcount_accumulator #(.IN_SIZE(4), .NUM_BEATS(1)) dut1 (
        .clk(clk), .rst(rst),
        .data_in(din1), .data_in_valid(vin1), .data_in_ready(rdy1),
        .data_out(dout1),
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
        .data_out_bin(bin1),
`endif
        .data_out_valid(vout1), .data_out_ready(ordy1)
    );

    typedef struct {
        logic [3:0] beats [4];
        int         cnt;
        logic       bin;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [3:0] b0, input logic [3:0] b1,
                           input logic [3:0] b2, input logic [3:0] b3, input int cnt, input logic b);
        vecs[idx].beats[0] = b0;
        vecs[idx].beats[1] = b1;
        vecs[idx].beats[2] = b2;
        vecs[idx].beats[3] = b3;
        vecs[idx].cnt      = cnt;
        vecs[idx].bin      = b;
    endtask

    // Present a beat at a falling edge and hold it until a rising edge accepts it.
    task automatic send_beat(input logic [3:0] b);
        int n;
        @(negedge clk);
        for (int i = 0; i < IN_SIZE; i++) din[i] = b[i];
        vin = 1'b1;
        n = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) check("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1 vin = 1'b0;
    endtask

    // Called right after the last beat: result must be valid in the very next cycle.
    task automatic expect_result(input int exp, input logic eb, input string tag);
        @(negedge clk);
        check({tag, "_valid"}, vout, 1);
        check({tag, "_in_ready_low"}, rdy, 0);
        check({tag, "_count"}, dout, exp);
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
        check({tag, "_bin"}, bin, eb);
`else
        if (eb === 1'bx) $display("note: unexpected X threshold for %s", tag);
`endif
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        @(negedge clk);
        check({tag, "_valid_clear"}, vout, 0);
        check({tag, "_in_ready_back"}, rdy, 1);
    endtask

    initial begin
        logic [3:0] gap_beats [4];
        logic [3:0] cur;
        int q[$];
        int sent, got, cyc;

        set_vec(0, 4'hF, 4'hF, 4'hF, 4'hF, 16, 1'b1);
        set_vec(1, 4'hA, 4'hA, 4'hA, 4'hA,  8, 1'b1);
        set_vec(2, 4'hF, 4'h7, 4'h0, 4'h0,  7, 1'b0);
        set_vec(3, 4'h1, 4'h2, 4'h4, 4'h8,  4, 1'b0);
        set_vec(4, 4'h0, 4'h0, 4'h0, 4'h0,  0, 1'b0);
        set_vec(5, 4'h3, 4'h7, 4'hF, 4'h1, 10, 1'b1);

        // Reset state
        #12;
        check("reset_in_ready", rdy, 0);
        check("reset_valid", vout, 0);
        check("reset_count", dout, 0);
        check("reset_in_ready_nb1", rdy1, 0);
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
        check("reset_bin", bin, 0);
`endif
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", rdy, 1);
        check("post_reset_valid", vout, 0);

        // Table vectors, no stalls
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) send_beat(vecs[v].beats[k]);
            expect_result(vecs[v].cnt, vecs[v].bin, $sformatf("vec%0d", v));
        end

        // Random idle gaps, downstream ready held high throughout
        gap_beats[0] = 4'h0; gap_beats[1] = 4'h1; gap_beats[2] = 4'h3; gap_beats[3] = 4'h7;
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("gap_no_early_result", vout, 0);
            end
            send_beat(gap_beats[k]);
        end
        expect_result(6, 1'b0, "gaps");
        repeat (3) begin
            @(negedge clk);
            check("gaps_single_result", vout, 0);
        end

        // Backpressure: result held 10 cycles while a beat is pending
        for (int k = 0; k < 4; k++) send_beat(4'hF);
        @(negedge clk);
        for (int i = 0; i < IN_SIZE; i++) din[i] = (i % 2 == 1);
        vin = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", vout, 1);
            check("stall_count", dout, 16);
            check("stall_in_ready", rdy, 0);
            @(negedge clk);
        end
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(4'hA);
        expect_result(8, 1'b1, "after_stall");

        // Reset mid-vector discards the partial sum
        send_beat(4'hF);
        send_beat(4'hF);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midvec_rst_valid", vout, 0);
        check("midvec_rst_in_ready", rdy, 0);
        check("midvec_rst_count", dout, 0);
        #1 rst = 1'b0;
        send_beat(4'h1);
        send_beat(4'h1);
        send_beat(4'h1);
        @(negedge clk);
        check("midvec_no_stale_result", vout, 0);
        send_beat(4'h1);
        expect_result(4, 1'b0, "after_rst");

        // Reset while a result is waiting in OUT
        for (int k = 0; k < 4; k++) send_beat(4'hF);
        @(negedge clk);
        check("midout_valid_before", vout, 1);
        #1 rst = 1'b1;
        #1;
        check("midout_rst_valid", vout, 0);
        check("midout_rst_count", dout, 0);
`ifdef BINARY_POPCOUNT_THRESHOLD_EN
        check("midout_rst_bin", bin, 0);
`endif
        #1 rst = 1'b0;
        @(negedge clk);
        check("midout_post_valid", vout, 0);
        check("midout_post_in_ready", rdy, 1);

        // NUM_BEATS = 1: back-to-back beats, random downstream ready
        sent = 0;
        got  = 0;
        cyc  = 0;
        cur  = 4'($urandom);
        while (got < 100 && cyc < 2000) begin
            for (int i = 0; i < IN_SIZE; i++) din1[i] = cur[i];
            vin1  = (sent < 100);
            ordy1 = 1'($urandom_range(0, 1));
            if (vout1 && ordy1) begin
                if (q.size() == 0) check("nb1_spurious_result", 1, 0);
                else check("nb1_count", dout1, q.pop_front());
                got++;
            end
            if (vin1 && rdy1) begin
                q.push_back($countones(cur));
                sent++;
                cur = 4'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        vin1  = 1'b0;
        ordy1 = 1'b0;
        check("nb1_all_received", got, 100);
        check("nb1_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
